// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : Registered EX-stage ALU. Logic, add/sub and signed SLT complete
//            in one cycle. Unsigned multiply (shift-add) and divide
//            (restoring) iterate one bit per cycle and write the HI/LO
//            registers. MFHI/MFLO read HI/LO back through the result port.
// Ports    : clk, rst_n (async, active-low)
//            start, alu_control[3:0], operand1, operand2   - request
//            result, zero                                  - registered result
//            hi, lo                                        - HI/LO registers
//            busy (iterating), done (one-cycle completion pulse)
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_SUB   = 4'b0110;
    localparam logic [3:0] c_OP_SLT   = 4'b0111;
    localparam logic [3:0] c_OP_MULTU = 4'b1000;
    localparam logic [3:0] c_OP_DIVU  = 4'b1001;
    localparam logic [3:0] c_OP_MFHI  = 4'b1010;
    localparam logic [3:0] c_OP_MFLO  = 4'b1011;
    localparam logic [3:0] c_OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    // Shared iteration register: upper half is the partial product /
    // remainder, lower half the remaining multiplier bits / quotient.
    logic [2*WIDTH-1:0]   r_acc;
    // Multiplicand for MULTU, divisor for DIVU.
    logic [WIDTH-1:0]     r_opnd;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_busy;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_alu_res;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_step_next;

    assign w_busy   = (r_state == S_MUL) || (r_state == S_DIV);
    assign w_accept = start && !w_busy;
    assign w_last   = (r_cnt == CNT_W'(1));

    // Single-cycle datapath, evaluated on the accepting edge.
    always_comb begin
        w_alu_res = '0;
        case (alu_control)
            c_OP_ADD:  w_alu_res = operand1 + operand2;
            c_OP_SUB:  w_alu_res = operand1 - operand2;
            c_OP_AND:  w_alu_res = operand1 & operand2;
            c_OP_OR:   w_alu_res = operand1 | operand2;
            c_OP_NOR:  w_alu_res = ~(operand1 | operand2);
            c_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}},
                                    ($signed(operand1) < $signed(operand2))};
            c_OP_MFHI: w_alu_res = r_hi;
            c_OP_MFLO: w_alu_res = r_lo;
            default:   w_alu_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit (LSB) is set, then shift the whole pair right by one.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: bring down the next dividend bit and trial-subtract.
    // The shifted remainder needs WIDTH+1 bits; the borrow is its MSB.
    // A zero divisor always "fits", which yields all-ones quotient and
    // leaves the dividend as remainder.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = !w_div_diff[WIDTH];
    assign w_div_next  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    assign w_step_next = (r_state == S_MUL) ? w_mul_next : w_div_next;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (alu_control == c_OP_MULTU)
                        w_state_next = S_MUL;
                    else if (alu_control == c_OP_DIVU)
                        w_state_next = S_DIV;
                    else
                        w_state_next = S_DONE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last)
                    w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt  <= CNT_W'(WIDTH);
                r_opnd <= (alu_control == c_OP_DIVU) ? operand2 : operand1;
                r_acc  <= {{WIDTH{1'b0}},
                           ((alu_control == c_OP_DIVU) ? operand1 : operand2)};
                if ((alu_control != c_OP_MULTU) && (alu_control != c_OP_DIVU)) begin
                    r_result <= w_alu_res;
                    r_zero   <= (w_alu_res == '0);
                end
            end else if (w_busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
                r_acc <= w_step_next;
                if (w_last) begin
                    // Mult: {hi,lo} = product. Div: hi = remainder, lo = quotient.
                    r_hi     <= w_step_next[2*WIDTH-1:WIDTH];
                    r_lo     <= w_step_next[WIDTH-1:0];
                    r_result <= w_step_next[WIDTH-1:0];
                    r_zero   <= (w_step_next[WIDTH-1:0] == '0);
                end
            end
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign busy   = w_busy;
    assign done   = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Purpose  : Self-checking bench for alu_muldiv_seq (WIDTH=32): directed
//            vector table, hand-written multi-cycle corner cases, and
//            randomized operations compared against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

    localparam int c_W = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [3:0]      alu_control;
    logic [c_W-1:0]  operand1;
    logic [c_W-1:0]  operand2;
    logic [c_W-1:0]  result;
    logic            zero;
    logic [c_W-1:0]  hi;
    logic [c_W-1:0]  lo;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_muldiv_seq #(.WIDTH(c_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .operand1    (operand1),
        .operand2    (operand2),
        .result      (result),
        .zero        (zero),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[17];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: plain arithmetic on the architectural HI/LO state.
    function automatic logic [31:0] model_op(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        case (op)
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                r = m_lo;
            end
            4'b1001: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                r = m_lo;
            end
            4'b1010: r = m_hi;
            4'b1011: r = m_lo;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen high.
    // inj > 0 drives an ADD request that many cycles into the operation.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [31:0] eh, input logic [31:0] el,
                          input logic [31:0] ph, input logic [31:0] pl, input int inj);
        int cyc;
        int bcnt;
        bit iter;
        bit held;
        iter = (op == 4'b1000) || (op == 4'b1001);
        start = 1'b1;
        alu_control = op;
        operand1 = a;
        operand2 = b;
        @(negedge clk);
        cyc = 1;
        bcnt = 0;
        held = 1'b1;
        start = 1'b0;
        // Operands must have been latched; scramble the inputs.
        operand1 = $urandom;
        operand2 = $urandom;
        while (!done && cyc < 200) begin
            if (busy) bcnt++;
            if (hi !== ph || lo !== pl) held = 1'b0;
            if (cyc == inj) begin
                start = 1'b1;
                alu_control = 4'b0010;
                operand1 = $urandom;
                operand2 = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("latency", 64'(cyc), iter ? 64'(c_W + 1) : 64'd1);
        chk("busy_cycles", 64'(bcnt), iter ? 64'(c_W) : 64'd0);
        if (iter) chk("hilo_held_while_busy", {63'd0, held}, 64'd1);
        chk("result", {32'd0, result}, {32'd0, er});
        chk("zero", {63'd0, zero}, {63'd0, (er == 32'd0)});
        chk("hi", {32'd0, hi}, {32'd0, eh});
        chk("lo", {32'd0, lo}, {32'd0, el});
    endtask

    logic [31:0] ph;
    logic [31:0] pl;
    logic [31:0] mres;
    logic [3:0]  rops[12];

    initial begin
        vecs[0]  = '{4'b0010, 32'd5,          32'd7,          32'd12,         32'd0, 32'd0};
        vecs[1]  = '{4'b0110, 32'd3,          32'd3,          32'd0,          32'd0, 32'd0};
        vecs[2]  = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          32'd0, 32'd0};
        vecs[3]  = '{4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          32'd0, 32'd0};
        vecs[4]  = '{4'b1100, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0, 32'd0};
        vecs[5]  = '{4'b1111, 32'd1234,       32'd5678,       32'd0,          32'd0, 32'd0};
        vecs[6]  = '{4'b0000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  32'd0, 32'd0};
        vecs[7]  = '{4'b0001, 32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  32'd0, 32'd0};
        vecs[8]  = '{4'b1000, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'd1, 32'hFFFF_FFFE};
        vecs[9]  = '{4'b1010, 32'd0,          32'd0,          32'd1,          32'd1, 32'hFFFF_FFFE};
        vecs[10] = '{4'b1011, 32'd0,          32'd0,          32'hFFFF_FFFE,  32'd1, 32'hFFFF_FFFE};
        vecs[11] = '{4'b1001, 32'd100,        32'd7,          32'd14,         32'd2, 32'd14};
        vecs[12] = '{4'b1010, 32'd0,          32'd0,          32'd2,          32'd2, 32'd14};
        vecs[13] = '{4'b1001, 32'd9,          32'd0,          32'hFFFF_FFFF,  32'd9, 32'hFFFF_FFFF};
        vecs[14] = '{4'b1011, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd9, 32'hFFFF_FFFF};
        vecs[15] = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd9, 32'hFFFF_FFFF};
        vecs[16] = '{4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  32'd9, 32'hFFFF_FFFF};

        rops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111,
                 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1111, 4'b0011};

        rst_n = 1'b0;
        start = 1'b0;
        alu_control = '0;
        operand1 = '0;
        operand2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd1);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table; most entries issued back-to-back from DONE.
        for (int i = 0; i < 17; i++) begin
            ph = m_hi;
            pl = m_lo;
            mres = model_op(vecs[i].op, vecs[i].a, vecs[i].b);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ehi, vecs[i].elo,
                   ph, pl, 0);
            if (i % 3 == 2) begin
                @(negedge clk);
                chk("done_one_cycle", {63'd0, done}, 64'd0);
            end
        end

        // ADD request mid-MULTU is ignored and not queued.
        ph = m_hi;
        pl = m_lo;
        mres = model_op(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, mres, m_hi, m_lo, ph, pl, 5);
        @(negedge clk);
        chk("ignored_start_not_queued", {63'd0, done || busy}, 64'd0);

        // Randomized operations against the model.
        for (int i = 0; i < 30; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = rops[$urandom_range(0, 11)];
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            ph = m_hi;
            pl = m_lo;
            mres = model_op(op, a, b);
            run_op(op, a, b, mres, m_hi, m_lo, ph, pl, 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Make HI/LO non-zero, then abort a DIVU with reset on its 10th cycle.
        ph = m_hi;
        pl = m_lo;
        mres = model_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mres, m_hi, m_lo, ph, pl, 0);
        start = 1'b1;
        alu_control = 4'b1001;
        operand1 = 32'd1000;
        operand2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_abort", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_zero", {63'd0, zero}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        run_op(4'b0010, 32'd2, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
